// File: rtl/mips_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch
// and data access; fixed 4-cycle transaction (IDLE, ISSUE, WAIT, DONE).
module mips_mem_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_ready_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              d_ready_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              cpu_stall_o,
  output logic [CNT_W-1:0]  if_count_o,
  output logic [CNT_W-1:0]  d_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;
  typedef enum logic {OWN_I, OWN_D} owner_e;

  state_e             state_q, state_d;
  owner_e             owner_q, owner_d;
  owner_e             last_q, last_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  d_rdata_q, d_rdata_d;
  logic [CNT_W-1:0]   if_cnt_q, if_cnt_d;
  logic [CNT_W-1:0]   d_cnt_q, d_cnt_d;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      owner_q    <= OWN_I;
      last_q     <= OWN_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_cnt_q   <= '0;
      d_cnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
      if_cnt_q   <= if_cnt_d;
      d_cnt_q    <= d_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;
    if_cnt_d   = if_cnt_q;
    d_cnt_d    = d_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_req_i || d_req_i) begin
          // On a tie the requester that did not win last time is served
          if (if_req_i && d_req_i) owner_d = (last_q == OWN_I) ? OWN_D : OWN_I;
          else if (d_req_i)        owner_d = OWN_D;
          else                     owner_d = OWN_I;
          last_d  = owner_d;
          addr_d  = (owner_d == OWN_D) ? d_addr_i : if_addr_i;
          we_d    = (owner_d == OWN_D) && d_we_i;
          wdata_d = d_wdata_i;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_DONE;
        if (!we_q) begin
          if (owner_q == OWN_I) if_rdata_d = mem_rdata_i;
          else                  d_rdata_d  = mem_rdata_i;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (owner_q == OWN_I) begin
          if (if_cnt_q != '1) if_cnt_d = if_cnt_q + CNT_W'(1);
        end else begin
          if (d_cnt_q != '1) d_cnt_d = d_cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign mem_en_o    = (state_q == S_ISSUE);
  assign mem_we_o    = (state_q == S_ISSUE) && we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign if_ready_o  = (state_q == S_DONE) && (owner_q == OWN_I);
  assign d_ready_o   = (state_q == S_DONE) && (owner_q == OWN_D);
  assign if_rdata_o  = if_rdata_q;
  assign d_rdata_o   = d_rdata_q;
  assign if_count_o  = if_cnt_q;
  assign d_count_o   = d_cnt_q;
  assign cpu_stall_o = (if_req_i && !if_ready_o) || (d_req_i && !d_ready_o);

endmodule
